mem_port_arbiter: RTL

- Sequences a single shared memory port between instruction fetch (IF, read-only) and data access (MEM stage, read/write) for the unified-memory pipelined MIPS core.
- Registered FSM with a req/ack handshake on the memory side, data-first priority with an IF anti-starvation limit, and a per-access ack timeout.
- Drives stall_if/stall_mem into the pipeline controller so the IF/ID and EX/MEM registers hold while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access.
// Data has priority, but IF is forced after MAX_DATA_STREAK data grants in a row.
module mem_port_arbiter #(
   parameter int unsigned MAX_DATA_STREAK = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 16,
   parameter logic [31:0] ERR_WORD        = 32'hDEADBEEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        timeout_err
);

   localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I, RESP} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   dm_rdata_q, dm_rdata_d;
   logic          if_ready_q, if_ready_d;
   logic          dm_ready_q, dm_ready_d;
   logic          timeout_err_q, timeout_err_d;
   logic          data_win;
   logic          done;

   always_comb begin
      state_d       = state_q;
      streak_d      = streak_q;
      tmo_d         = tmo_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      if_rdata_d    = if_rdata_q;
      dm_rdata_d    = dm_rdata_q;
      if_ready_d    = 1'b0;
      dm_ready_d    = 1'b0;
      timeout_err_d = timeout_err_q;
      data_win      = 1'b0;
      done          = 1'b0;

      case (state_q)
         IDLE: begin
            data_win = dm_req && !(if_req && streak_q == SW'(MAX_DATA_STREAK));
            // A data win with if_req pending implies streak < MAX, so +1 never overshoots.
            streak_d = (data_win && if_req) ? streak_q + SW'(1) : '0;
            if (data_win) begin
               state_d     = GRANT_D;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
               tmo_d       = '0;
            end else if (if_req) begin
               state_d    = GRANT_I;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr;
               tmo_d      = '0;
            end
         end
         GRANT_D, GRANT_I: begin
            done = mem_ack || (tmo_q == TW'(TIMEOUT_CYCLES - 1));
            if (done) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (!mem_ack) begin
                  timeout_err_d = 1'b1;
               end
               if (state_q == GRANT_I) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = mem_ack ? mem_rdata : ERR_WORD;
               end else begin
                  dm_ready_d = 1'b1;
                  if (!mem_we_q) begin
                     dm_rdata_d = mem_ack ? mem_rdata : ERR_WORD;
                  end
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         streak_q      <= '0;
         tmo_q         <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         if_rdata_q    <= '0;
         dm_rdata_q    <= '0;
         if_ready_q    <= 1'b0;
         dm_ready_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         streak_q      <= streak_d;
         tmo_q         <= tmo_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         if_rdata_q    <= if_rdata_d;
         dm_rdata_q    <= dm_rdata_d;
         if_ready_q    <= if_ready_d;
         dm_ready_q    <= dm_ready_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign if_rdata    = if_rdata_q;
   assign dm_rdata    = dm_rdata_q;
   assign if_ready    = if_ready_q;
   assign dm_ready    = dm_ready_q;
   assign timeout_err = timeout_err_q;
   assign stall_if    = if_req & ~if_ready_q;
   assign stall_mem   = dm_req & ~dm_ready_q;

endmodule
